// File: rtl/clk_div_ctrl_if.sv
// Request channel for the divider sequencer: target ratio offered over valid/ready.
interface clk_div_ctrl_if #(
  parameter int SIZE = 3
);
  logic            req_valid;
  logic            req_ready;
  logic [SIZE-1:0] req_div;

  modport master (output req_valid, output req_div, input req_ready);
  modport slave  (input req_valid, input req_div, output req_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Sequencer for the integer-N core clock divider: ramps N one step at a time with a
// settle dwell per step, holds the divider in reset after rst, and forces N_MAX on demand.
module clk_div_ctrl #(
  parameter int SIZE     = 3,
  parameter int N_MIN    = 2,
  parameter int N_MAX    = 7,
  parameter int RESET_N  = 2,
  parameter int SETTLE   = 16,
  parameter int RST_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_ctrl_if.slave   req,
  input  logic            force_slow_i,
  input  logic            err_clr_i,
  output logic [SIZE-1:0] div_n_o,
  output logic            div_resetb_o,
  output logic            busy_o,
  output logic            locked_o,
  output logic            err_o
);

  localparam int CNT_MAX = (SETTLE > RST_HOLD) ? SETTLE : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] RST_HOLD_C = CNT_W'(RST_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [SIZE-1:0]  N_MIN_C    = SIZE'(N_MIN);
  localparam logic [SIZE-1:0]  N_MAX_C    = SIZE'(N_MAX);
  localparam logic [SIZE-1:0]  RESET_N_C  = SIZE'(RESET_N);
  localparam logic [SIZE-1:0]  N_ONE      = SIZE'(1);

  typedef enum logic [1:0] {S_HOLD, S_SETTLE, S_IDLE, S_STEP} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] div_n_q, div_n_d;
  logic [SIZE-1:0] target_q, target_d;
  logic            div_resetb_q, div_resetb_d;
  logic            err_q, err_d;

  logic [SIZE-1:0] req_clamped;
  logic            clamp_hit;
  logic            xfer;

  // Out-of-range requests are folded into the legal window and flagged.
  always_comb begin
    req_clamped = req.req_div;
    clamp_hit   = 1'b0;
    if (req.req_div < N_MIN_C) begin
      req_clamped = N_MIN_C;
      clamp_hit   = 1'b1;
    end else if (req.req_div > N_MAX_C) begin
      req_clamped = N_MAX_C;
      clamp_hit   = 1'b1;
    end
  end

  assign req.req_ready = (state_q == S_IDLE) && !force_slow_i;
  assign xfer          = req.req_valid && req.req_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_n_d      = div_n_q;
    target_d     = target_q;
    div_resetb_d = div_resetb_q;
    err_d        = err_q;

    if (err_clr_i) err_d = 1'b0;

    unique case (state_q)
      S_HOLD: begin
        div_resetb_d = 1'b0;
        if (cnt_q == CNT_ONE) begin
          state_d      = S_SETTLE;
          cnt_d        = SETTLE_C;
          div_resetb_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = (div_n_q == target_q) ? S_IDLE : S_STEP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_IDLE: begin
        if (xfer) begin
          target_d = req_clamped;
          if (clamp_hit) err_d = 1'b1;
          if (req_clamped != div_n_q) state_d = S_STEP;
        end
      end
      S_STEP: begin
        div_n_d = (target_q > div_n_q) ? div_n_q + N_ONE : div_n_q - N_ONE;
        state_d = S_SETTLE;
        cnt_d   = SETTLE_C;
      end
      default: state_d = S_HOLD;
    endcase

    // Thermal override: jump straight to the slowest ratio and keep re-arming the dwell.
    if (force_slow_i && (state_q != S_HOLD)) begin
      div_n_d  = N_MAX_C;
      target_d = N_MAX_C;
      state_d  = S_SETTLE;
      cnt_d    = SETTLE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HOLD;
      cnt_q        <= RST_HOLD_C;
      div_n_q      <= RESET_N_C;
      target_q     <= RESET_N_C;
      div_resetb_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_n_q      <= div_n_d;
      target_q     <= target_d;
      div_resetb_q <= div_resetb_d;
      err_q        <= err_d;
    end
  end

  assign div_n_o      = div_n_q;
  assign div_resetb_o = div_resetb_q;
  assign busy_o       = (state_q != S_IDLE);
  assign locked_o     = (state_q == S_IDLE) && (div_n_q == target_q);
  assign err_o        = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: table of ramp requests plus hand sequences for
// back-pressure, force_slow and reset mid-ramp.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       force_slow;
  logic       err_clr;
  logic [2:0] div_n;
  logic       div_resetb;
  logic       busy;
  logic       locked;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_ctrl_if #(.SIZE(3)) req_if ();

  clk_div_ctrl #(
    .SIZE(3), .N_MIN(2), .N_MAX(7), .RESET_N(2), .SETTLE(4), .RST_HOLD(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req_if),
    .force_slow_i (force_slow),
    .err_clr_i    (err_clr),
    .div_n_o      (div_n),
    .div_resetb_o (div_resetb),
    .busy_o       (busy),
    .locked_o     (locked),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req_div;
    logic       clr;
    logic [2:0] exp_n;
    logic       exp_err;
    int         exp_lock;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    chk("rst_div_n", div_n, 2);
    chk("rst_resetb", div_resetb, 0);
    chk("rst_busy", busy, 1);
    chk("rst_locked", locked, 0);
    chk("rst_ready", req_if.req_ready, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) chk("hold_resetb_low", div_resetb, 0);
      if (i == 4) chk("hold_resetb_rise", div_resetb, 1);
      if (i == 7) chk("settle_not_locked", locked, 0);
      if (i == 8) begin
        chk("post_rst_locked", locked, 1);
        chk("post_rst_ready", req_if.req_ready, 1);
        chk("post_rst_div_n", div_n, 2);
      end
    end
  endtask

  task automatic send(input logic [2:0] d, input logic clr);
    int w;
    w = 0;
    while (!req_if.req_ready && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) chk("ready_timeout", 0, 1);
    req_if.req_valid = 1'b1;
    req_if.req_div   = d;
    err_clr          = clr;
    tick();
    req_if.req_valid = 1'b0;
    err_clr          = 1'b0;
    $display("txn req_div=%0d clr=%0d -> div_n=%0d err=%0d", d, clr, div_n, err);
  endtask

  task automatic wait_lock(output int cyc, output int busy_cnt, output int max_delta);
    int prev;
    int d;
    cyc = 0;
    busy_cnt = 0;
    max_delta = 0;
    prev = int'(div_n);
    while (!locked && cyc < 200) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
      d = int'(div_n) - prev;
      if (d < 0) d = -d;
      if (d > max_delta) max_delta = d;
      prev = int'(div_n);
    end
  endtask

  initial begin
    int cyc, bcnt, mdel, rdy_cnt;

    vecs[0] = '{3'd5, 1'b0, 3'd5, 1'b0, 15};  // ramp up 2->5
    vecs[1] = '{3'd0, 1'b0, 3'd2, 1'b1, 15};  // clamp low, ramp down 5->2
    vecs[2] = '{3'd7, 1'b1, 3'd7, 1'b0, 25};  // err_clr with legal request
    vecs[3] = '{3'd1, 1'b1, 3'd2, 1'b1, 25};  // err_clr loses to clamp
    vecs[4] = '{3'd4, 1'b1, 3'd4, 1'b0, 10};
    vecs[5] = '{3'd4, 1'b0, 3'd4, 1'b0, 0};   // no-op at current ratio

    rst = 1'b1;
    force_slow = 1'b0;
    err_clr = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_div = 3'd0;

    apply_reset(3);
    release_reset();

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].req_div, vecs[i].clr);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      wait_lock(cyc, bcnt, mdel);
      chk($sformatf("v%0d_lock_cycles", i), cyc, vecs[i].exp_lock);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_lock);
      chk($sformatf("v%0d_max_step", i), mdel, (vecs[i].exp_lock > 0) ? 1 : 0);
      chk($sformatf("v%0d_div_n", i), div_n, vecs[i].exp_n);
      chk($sformatf("v%0d_ready", i), req_if.req_ready, 1);
    end

    // Back-pressure: a competing request during a 4->6 ramp must be ignored.
    send(3'd6, 1'b0);
    req_if.req_valid = 1'b1;
    req_if.req_div   = 3'd2;
    rdy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (req_if.req_ready) rdy_cnt++;
      tick();
    end
    req_if.req_valid = 1'b0;
    chk("bp_ready_high_cycles", rdy_cnt, 0);
    wait_lock(cyc, bcnt, mdel);
    chk("bp_lock_remaining", cyc, 5);
    chk("bp_div_n", div_n, 6);

    send(3'd2, 1'b0);
    wait_lock(cyc, bcnt, mdel);
    chk("down_to_2_cycles", cyc, 20);

    // force_slow pulse during a 2->5 ramp while div_n==3.
    send(3'd5, 1'b0);
    tick();
    tick();
    chk("fs_pre_div_n", div_n, 3);
    force_slow = 1'b1;
    tick();
    force_slow = 1'b0;
    chk("fs_jump_div_n", div_n, 7);
    chk("fs_busy", busy, 1);
    wait_lock(cyc, bcnt, mdel);
    chk("fs_lock_cycles", cyc, 4);
    chk("fs_locked_div_n", div_n, 7);

    // force_slow held in IDLE alongside a request: request must not transfer.
    chk("fsi_ready_before", req_if.req_ready, 1);
    force_slow = 1'b1;
    req_if.req_valid = 1'b1;
    req_if.req_div = 3'd3;
    #1;
    chk("fsi_ready_blocked", req_if.req_ready, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("fsi_busy_held", busy, 1);
    chk("fsi_ready_held", req_if.req_ready, 0);
    force_slow = 1'b0;
    req_if.req_valid = 1'b0;
    wait_lock(cyc, bcnt, mdel);
    chk("fsi_lock_cycles", cyc, 4);
    chk("fsi_div_n", div_n, 7);

    // Reset mid-ramp 7->2, taken when div_n has reached 4.
    send(3'd2, 1'b0);
    for (int k = 0; k < 11; k++) tick();
    chk("midrst_pre_div_n", div_n, 4);
    apply_reset(1);
    release_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
